// File: rtl/gpu_pkg.sv
// Shared constants for the pixel pipeline: pixel/colour widths and the
// control-bit positions inside the current-tile (CT) and current-line (CPL)
// words.
package gpu_pkg;

  localparam int WORD_W       = 16;
  localparam int PIX_W        = 6;
  localparam int PIX_PER_TILE = 8;
  localparam int CP_W         = PIX_W * PIX_PER_TILE;
  localparam int IDX_W        = 3;

  localparam int R_W   = 2;
  localparam int G_W   = 2;
  localparam int B_W   = 2;
  localparam int RGB_W = R_W + G_W + B_W;

  // Tile attribute bits (CT); bits above CT_FLAG_W-1 are reserved.
  localparam int CT_HFLIP   = 0;
  localparam int CT_TRANSP  = 1;
  localparam int CT_INVERT  = 2;
  localparam int CT_FLAG_W  = 3;

  // Line attribute bits (CPL); bits 14:6 are reserved.
  localparam int CPL_LINE_OFF = 15;
  localparam int CPL_BG_MSB   = 5;
  localparam int CPL_BG_LSB   = 0;

endpackage

// File: rtl/gpu_pixel_resolve.sv
// Combinational pixel select and colour resolve.
// Optional feature: define GPU_PIPE_HFLIP_EN to honour the per-tile
// horizontal-flip bit; otherwise pixels are always taken left to right.
module gpu_pixel_resolve
  import gpu_pkg::*;
(
  input  logic [CP_W-1:0]      cp,
  input  logic [CT_FLAG_W-1:0] ct_flags,
  input  logic                 line_off,
  input  logic [PIX_W-1:0]     bg,
  input  logic [IDX_W-1:0]     x_pos,
  input  logic                 blank,
  output logic [RGB_W-1:0]     colour
);

  logic [IDX_W-1:0] idx;
  logic [PIX_W-1:0] pix;

`ifdef GPU_PIPE_HFLIP_EN
  // Pixel index, mirrored within the tile when the tile is flipped
  always_comb begin
    idx = x_pos;
    if (ct_flags[CT_HFLIP]) idx = 3'd7 - x_pos;
  end
`else
  logic unused_hflip;
  assign unused_hflip = ct_flags[CT_HFLIP];

  // Pixel index follows the column directly
  always_comb begin
    idx = x_pos;
  end
`endif

  assign pix = cp[idx*PIX_W +: PIX_W];

  // Colour priority: blanking, line off, transparent background, invert
  always_comb begin
    colour = '0;
    if (blank) begin
      colour = '0;
    end else if (line_off) begin
      colour = '0;
    end else if ((pix == '0) && ct_flags[CT_TRANSP]) begin
      colour = bg;
    end else begin
      colour = pix ^ {PIX_W{ct_flags[CT_INVERT]}};
    end
  end

endmodule

// File: rtl/gpu_pixel_pipe.sv
// Pixel output pipeline: double-buffered tile/pixel/line registers fed from
// video memory, a combinational resolve stage, and one output register stage
// that keeps colour and timing aligned.
// Optional feature: GPU_PIPE_HFLIP_EN (horizontal tile flip via CT[0]).
module gpu_pixel_pipe
  import gpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] memData,
  input  logic              enNT,
  input  logic              enNP1,
  input  logic              enNP2,
  input  logic              enNP3,
  input  logic              enNPL,
  input  logic              enCP,
  input  logic              enCT,
  input  logic              enCPL,
  input  logic [IDX_W-1:0]  xPos,
  input  logic              blank,
  input  logic              hSync,
  input  logic              vSync,
  output logic [RGB_W-1:0]  rgbOut,
  output logic              hSyncOut,
  output logic              vSyncOut,
  output logic              blankOut
);

  logic [WORD_W-1:0] nt, np1, np2, np3, npl;
  logic [WORD_W-1:0] ct, cpl;
  logic [CP_W-1:0]   cp;

  logic [RGB_W-1:0]  colour_p0;
  logic [RGB_W-1:0]  rgb_p1;
  logic              hsync_p1, vsync_p1, blank_p1;

  logic unused_reserved;
  assign unused_reserved = ^{ct[WORD_W-1:CT_FLAG_W], cpl[CPL_LINE_OFF-1:CPL_BG_MSB+1]};

  // Next registers: latch memory words on their load strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      nt  <= '0;
      np1 <= '0;
      np2 <= '0;
      np3 <= '0;
      npl <= '0;
    end else begin
      if (enNT)  nt  <= memData;
      if (enNP1) np1 <= memData;
      if (enNP2) np2 <= memData;
      if (enNP3) np3 <= memData;
      if (enNPL) npl <= memData;
    end
  end

  // Current registers: transfers see the pre-edge next values
  always_ff @(posedge clk) begin
    if (rst) begin
      cp  <= '0;
      ct  <= '0;
      cpl <= '0;
    end else begin
      if (enCP)  cp  <= {np3, np2, np1};
      if (enCT)  ct  <= nt;
      if (enCPL) cpl <= npl;
    end
  end

  // ---- stage p0: combinational pixel select and colour resolve ----
  gpu_pixel_resolve u_resolve (
    .cp       (cp),
    .ct_flags (ct[CT_FLAG_W-1:0]),
    .line_off (cpl[CPL_LINE_OFF]),
    .bg       (cpl[CPL_BG_MSB:CPL_BG_LSB]),
    .x_pos    (xPos),
    .blank    (blank),
    .colour   (colour_p0)
  );

  // ---- stage p1: register colour and timing together ----
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_p1   <= '0;
      hsync_p1 <= 1'b1;
      vsync_p1 <= 1'b1;
      blank_p1 <= 1'b1;
    end else begin
      rgb_p1   <= colour_p0;
      hsync_p1 <= hSync;
      vsync_p1 <= vSync;
      blank_p1 <= blank;
    end
  end

  assign rgbOut   = rgb_p1;
  assign hSyncOut = hsync_p1;
  assign vSyncOut = vsync_p1;
  assign blankOut = blank_p1;

endmodule

// File: tb/tb_gpu_pixel_pipe.sv
// Testbench for gpu_pixel_pipe: behavioural model with per-cycle compare,
// plus directed vectors with literal expected colours.
module tb_gpu_pixel_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] memData;
  logic        enNT, enNP1, enNP2, enNP3, enNPL, enCP, enCT, enCPL;
  logic [2:0]  xPos;
  logic        blank, hSync, vSync;
  logic [5:0]  rgbOut;
  logic        hSyncOut, vSyncOut, blankOut;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  gpu_pixel_pipe dut (
    .clk(clk), .rst(rst), .memData(memData),
    .enNT(enNT), .enNP1(enNP1), .enNP2(enNP2), .enNP3(enNP3), .enNPL(enNPL),
    .enCP(enCP), .enCT(enCT), .enCPL(enCPL),
    .xPos(xPos), .blank(blank), .hSync(hSync), .vSync(vSync),
    .rgbOut(rgbOut), .hSyncOut(hSyncOut), .vSyncOut(vSyncOut), .blankOut(blankOut)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [15:0] m_nt, m_np1, m_np2, m_np3, m_npl, m_ct, m_cpl;
  logic [47:0] m_cp;
  logic [5:0]  e_rgb;
  logic        e_hs, e_vs, e_bl;

  function automatic logic [5:0] model_colour(input logic [47:0] cpw, input logic [15:0] ctw,
                                              input logic [15:0] cplw, input logic [2:0] x,
                                              input logic bl);
    int idx;
    logic [47:0] sh;
    logic [5:0] p;
    if (bl) return 6'h00;
    if (cplw[15]) return 6'h00;
    idx = int'(x);
`ifdef GPU_PIPE_HFLIP_EN
    if (ctw[0]) idx = 7 - int'(x);
`endif
    sh = cpw >> (6 * idx);
    p  = sh[5:0];
    if (p == 6'h00 && ctw[1]) return cplw[5:0];
    if (ctw[2]) return 6'h3F - p;
    return p;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_nt <= '0; m_np1 <= '0; m_np2 <= '0; m_np3 <= '0; m_npl <= '0;
      m_ct <= '0; m_cpl <= '0; m_cp <= '0;
      e_rgb <= '0; e_hs <= 1'b1; e_vs <= 1'b1; e_bl <= 1'b1;
    end else begin
      e_rgb <= model_colour(m_cp, m_ct, m_cpl, xPos, blank);
      e_hs  <= hSync;
      e_vs  <= vSync;
      e_bl  <= blank;
      if (enNT)  m_nt  <= memData;
      if (enNP1) m_np1 <= memData;
      if (enNP2) m_np2 <= memData;
      if (enNP3) m_np3 <= memData;
      if (enNPL) m_npl <= memData;
      if (enCP)  m_cp  <= {m_np3, m_np2, m_np1};
      if (enCT)  m_ct  <= m_nt;
      if (enCPL) m_cpl <= m_npl;
    end
  end

  // Per-cycle compare against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      total++;
      if (rgbOut !== e_rgb) begin
        bad++;
        $display("FAIL model_rgb t=%0t got=%h exp=%h", $time, rgbOut, e_rgb);
      end
      total++;
      if ({hSyncOut, vSyncOut, blankOut} !== {e_hs, e_vs, e_bl}) begin
        bad++;
        $display("FAIL model_timing t=%0t got=%b exp=%b", $time,
                 {hSyncOut, vSyncOut, blankOut}, {e_hs, e_vs, e_bl});
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_strobes();
    enNT = 0; enNP1 = 0; enNP2 = 0; enNP3 = 0; enNPL = 0;
    enCP = 0; enCT = 0; enCPL = 0;
  endtask

  task automatic lit(input string name, input logic [5:0] got, input logic [5:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Load one next register from memory for a single cycle
  task automatic load(input int which, input logic [15:0] d);
    memData = d;
    case (which)
      0: enNT  = 1;
      1: enNP1 = 1;
      2: enNP2 = 1;
      3: enNP3 = 1;
      default: enNPL = 1;
    endcase
    step();
    clr_strobes();
  endtask

  task automatic transfer_all();
    enCP = 1; enCT = 1; enCPL = 1;
    step();
    clr_strobes();
  endtask

  // Sweep the tile and compare each output against a literal table entry
  task automatic sweep(input string name, input logic [5:0] tbl [8]);
    for (int k = 0; k < 8; k++) begin
      xPos = 3'(k);
      step();
      lit($sformatf("%s_x%0d", name, k), rgbOut, tbl[k]);
    end
  endtask

  logic [5:0] tbl [8];

  initial begin
    rst = 1; memData = 0; clr_strobes();
    xPos = 0; blank = 1; hSync = 1; vSync = 1;
    step();
    chk_en = 1;
    step();
    lit("reset_rgb", rgbOut, 6'h00);
    lit("reset_sync", {3'b0, hSyncOut, vSyncOut, blankOut}, 6'b000111);
    rst = 0;

    // Basic pattern: NP1=0FC0 puts 3F in pixel 1 only
    load(1, 16'h0FC0); load(2, 16'h0000); load(3, 16'h0000);
    load(0, 16'h0000); load(4, 16'h0000);
    transfer_all();
    blank = 0;
    tbl = '{6'h00, 6'h3F, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
    sweep("plain", tbl);

    // Transparent with background 15
    load(0, 16'h0002); load(4, 16'h0015);
    transfer_all();
    tbl = '{6'h15, 6'h3F, 6'h15, 6'h15, 6'h15, 6'h15, 6'h15, 6'h15};
    sweep("transp", tbl);

    // Invert, background off
    load(0, 16'h0004); load(4, 16'h0000);
    transfer_all();
    tbl = '{6'h3F, 6'h00, 6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h3F};
    sweep("invert", tbl);

    // Line off forces black
    load(4, 16'h8000);
    transfer_all();
    tbl = '{default: 6'h00};
    sweep("lineoff", tbl);

    // Blanking forces black even with visible data
    load(4, 16'h0000);
    transfer_all();
    blank = 1; xPos = 2; step();
    lit("blank", rgbOut, 6'h00);
    blank = 0;

    // Horizontal flip: pixel 0 = 21
    load(1, 16'h0021); load(0, 16'h0001);
    transfer_all();
    tbl = '{default: 6'h00};
`ifdef GPU_PIPE_HFLIP_EN
    tbl[7] = 6'h21;
`else
    tbl[0] = 6'h21;
`endif
    sweep("hflip", tbl);

    // Load and transfer in the same cycle: CP takes the old NP1
    load(0, 16'h0000); enCT = 1; step(); clr_strobes();
    memData = 16'hAAAA; enNP1 = 1; enCP = 1; step(); clr_strobes();
    xPos = 0; step();
    lit("same_cycle_old", rgbOut, 6'h21);
    enCP = 1; step(); clr_strobes();
    xPos = 0; step();
    lit("same_cycle_new", rgbOut, 6'h2A);

    // Reset mid-tile with strobes asserted and syncs active
    hSync = 0; vSync = 0; xPos = 3; step();
    rst = 1; memData = 16'hFFFF; enNP1 = 1; enCP = 1; enCT = 1;
    step();
    clr_strobes(); rst = 0;
    lit("rst_mid_rgb", rgbOut, 6'h00);
    lit("rst_mid_sync", {3'b0, hSyncOut, vSyncOut, blankOut}, 6'b000111);
    transfer_all();
    tbl = '{default: 6'h00};
    sweep("post_reset", tbl);

    hSync = 1; vSync = 1; blank = 1;
    step(); step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
